// File: rtl/bp_fe_bht_upd_sched.sv
// BHT update scheduler: buffers resolved-branch updates in a small FIFO and drains
// one per cycle onto the BHT write port. Optional stats counters: BP_FE_BHT_UPD_STATS_EN.
module bp_fe_bht_upd_sched #(
    parameter int unsigned bht_idx_width_p = 9,
    parameter int unsigned fifo_els_p      = 4,
    parameter int unsigned flush_cycles_p  = 2
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  upd_v_i,
    input  logic [bht_idx_width_p-1:0]            upd_idx_i,
    input  logic                                  upd_correct_i,
    output logic                                  upd_ready_o,
    input  logic                                  hold_i,
    input  logic                                  flush_i,
    output logic                                  w_v_o,
    output logic [bht_idx_width_p-1:0]            idx_w_o,
    output logic                                  correct_o,
    output logic [$clog2(fifo_els_p+1)-1:0]       pending_o,
    output logic                                  empty_o
`ifdef BP_FE_BHT_UPD_STATS_EN
    ,
    output logic [15:0]                           stat_wr_o,
    output logic [15:0]                           stat_drop_o
`endif
);

    localparam int unsigned ptr_width_lp   = $clog2(fifo_els_p);
    localparam int unsigned cnt_width_lp   = $clog2(fifo_els_p + 1);
    localparam int unsigned fcnt_width_lp  = (flush_cycles_p > 1) ? $clog2(flush_cycles_p) : 1;
    localparam int unsigned entry_width_lp = bht_idx_width_p + 1;

    localparam logic [0:0] e_run   = 1'b0;
    localparam logic [0:0] e_flush = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [fcnt_width_lp-1:0]  fcnt_q, fcnt_d;
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [cnt_width_lp-1:0]   count_q, count_d;
    logic [entry_width_lp-1:0] mem_q [fifo_els_p];
    logic [entry_width_lp-1:0] mem_d [fifo_els_p];

    logic full_c, empty_c, enq_c, deq_c;

    // Handshake and write-port decode from current state
    always_comb begin
        full_c      = (count_q == cnt_width_lp'(fifo_els_p));
        empty_c     = (count_q == '0);
        upd_ready_o = (state_q == e_run) & ~full_c & ~flush_i;
        w_v_o       = (state_q == e_run) & ~empty_c & ~hold_i & ~flush_i;
        enq_c       = upd_v_i & upd_ready_o;
        deq_c       = w_v_o;
        {idx_w_o, correct_o} = mem_q[rd_ptr_q];
        pending_o   = count_q;
        empty_o     = empty_c;
    end

    // Next-state: flush wins over enqueue/dequeue in the same cycle
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (flush_i) begin
            state_d  = e_flush;
            fcnt_d   = fcnt_width_lp'(flush_cycles_p - 1);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_c) begin
                mem_d[wr_ptr_q] = {upd_idx_i, upd_correct_i};
                wr_ptr_d        = wr_ptr_q + ptr_width_lp'(1);
            end
            if (deq_c) begin
                rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
            end
            if (enq_c && !deq_c) begin
                count_d = count_q + cnt_width_lp'(1);
            end else if (!enq_c && deq_c) begin
                count_d = count_q - cnt_width_lp'(1);
            end
            if (state_q == e_flush) begin
                if (fcnt_q == '0) begin
                    state_d = e_run;
                end else begin
                    fcnt_d = fcnt_q - fcnt_width_lp'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= e_run;
            fcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(fifo_els_p); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef BP_FE_BHT_UPD_STATS_EN
    logic [15:0] stat_wr_q, stat_wr_d;
    logic [15:0] stat_drop_q, stat_drop_d;
    logic [16:0] drop_sum_c;

    // Saturating counters: writes issued, entries discarded by flush
    always_comb begin
        stat_wr_d   = stat_wr_q;
        stat_drop_d = stat_drop_q;
        drop_sum_c  = 17'(stat_drop_q) + 17'(count_q);
        if (w_v_o && (stat_wr_q != 16'hFFFF)) begin
            stat_wr_d = stat_wr_q + 16'd1;
        end
        if (flush_i) begin
            stat_drop_d = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stat_wr_q   <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_wr_q   <= stat_wr_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_wr_o   = stat_wr_q;
    assign stat_drop_o = stat_drop_q;
`endif

endmodule

// File: tb/tb_bp_fe_bht_upd_sched.sv
// Directed self-checking bench for bp_fe_bht_upd_sched (stats checks when BP_FE_BHT_UPD_STATS_EN).
module tb_bp_fe_bht_upd_sched;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       upd_v_i = 1'b0;
    logic [8:0] upd_idx_i = '0;
    logic       upd_correct_i = 1'b0;
    logic       upd_ready_o;
    logic       hold_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       w_v_o;
    logic [8:0] idx_w_o;
    logic       correct_o;
    logic [2:0] pending_o;
    logic       empty_o;
`ifdef BP_FE_BHT_UPD_STATS_EN
    logic [15:0] stat_wr_o;
    logic [15:0] stat_drop_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    bp_fe_bht_upd_sched #(
        .bht_idx_width_p(9),
        .fifo_els_p     (4),
        .flush_cycles_p (2)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .upd_v_i      (upd_v_i),
        .upd_idx_i    (upd_idx_i),
        .upd_correct_i(upd_correct_i),
        .upd_ready_o  (upd_ready_o),
        .hold_i       (hold_i),
        .flush_i      (flush_i),
        .w_v_o        (w_v_o),
        .idx_w_o      (idx_w_o),
        .correct_o    (correct_o),
        .pending_o    (pending_o),
        .empty_o      (empty_o)
`ifdef BP_FE_BHT_UPD_STATS_EN
        ,
        .stat_wr_o    (stat_wr_o),
        .stat_drop_o  (stat_drop_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Apply inputs at the falling edge, then settle before sampling
    task automatic drive(input logic v, input int idx, input logic c, input logic hold, input logic flush);
        @(negedge clk_i);
        upd_v_i       = v;
        upd_idx_i     = 9'(idx);
        upd_correct_i = c;
        hold_i        = hold;
        flush_i       = flush;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        upd_v_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        int q[$];
        int mc, sent, wr, exp_idx;
        logic acc;

        // Reset values while reset is asserted
        #1;
        chk("rst_ready", 32'(upd_ready_o), 1);
        chk("rst_wv", 32'(w_v_o), 0);
        chk("rst_pending", 32'(pending_o), 0);
        chk("rst_empty", 32'(empty_o), 1);
        do_reset();

        // Three back-to-back updates, no bypass on empty
        drive(1, 5, 1, 0, 0);
        chk("t1_ready0", 32'(upd_ready_o), 1);
        chk("t1_wv0", 32'(w_v_o), 0);
        drive(1, 9, 0, 0, 0);
        chk("t1_wv1", 32'(w_v_o), 1);
        chk("t1_idx1", 32'(idx_w_o), 5);
        chk("t1_c1", 32'(correct_o), 1);
        drive(1, 5, 0, 0, 0);
        chk("t1_wv2", 32'(w_v_o), 1);
        chk("t1_idx2", 32'(idx_w_o), 9);
        chk("t1_c2", 32'(correct_o), 0);
        drive(0, 0, 0, 0, 0);
        chk("t1_wv3", 32'(w_v_o), 1);
        chk("t1_idx3", 32'(idx_w_o), 5);
        chk("t1_c3", 32'(correct_o), 0);
        drive(0, 0, 0, 0, 0);
        chk("t1_wv4", 32'(w_v_o), 0);
        chk("t1_pending", 32'(pending_o), 0);
        chk("t1_empty", 32'(empty_o), 1);

        // Hold: fill to 4, fifth stalls, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1, 20 + i, 1'(i), 1, 0);
            chk("t2_ready_fill", 32'(upd_ready_o), 1);
            chk("t2_wv_hold", 32'(w_v_o), 0);
        end
        drive(1, 24, 0, 1, 0);
        chk("t2_ready_full", 32'(upd_ready_o), 0);
        chk("t2_pending4", 32'(pending_o), 4);
        chk("t2_wv_full", 32'(w_v_o), 0);
        drive(1, 24, 0, 0, 0);
        chk("t2_ready_nopass", 32'(upd_ready_o), 0);
        chk("t2_wv_a", 32'(w_v_o), 1);
        chk("t2_idx_a", 32'(idx_w_o), 20);
        drive(1, 24, 0, 0, 0);
        chk("t2_ready_rise", 32'(upd_ready_o), 1);
        chk("t2_wv_b", 32'(w_v_o), 1);
        chk("t2_idx_b", 32'(idx_w_o), 21);
        chk("t2_c_b", 32'(correct_o), 1);
        drive(0, 0, 0, 0, 0);
        chk("t2_idx_c", 32'(idx_w_o), 22);
        chk("t2_wv_c", 32'(w_v_o), 1);
        drive(0, 0, 0, 0, 0);
        chk("t2_idx_d", 32'(idx_w_o), 23);
        chk("t2_wv_d", 32'(w_v_o), 1);
        drive(0, 0, 0, 0, 0);
        chk("t2_idx_e", 32'(idx_w_o), 24);
        chk("t2_wv_e", 32'(w_v_o), 1);
        drive(0, 0, 0, 0, 0);
        chk("t2_wv_done", 32'(w_v_o), 0);
        chk("t2_empty", 32'(empty_o), 1);

        // Flush with 3 queued entries concurrent with a valid update
        for (int i = 0; i < 3; i++) drive(1, 30 + i, 0, 1, 0);
        drive(1, 33, 1, 0, 1);
        chk("t3_ready_flush", 32'(upd_ready_o), 0);
        chk("t3_wv_flush", 32'(w_v_o), 0);
        drive(1, 34, 1, 0, 0);
        chk("t3_ready_f1", 32'(upd_ready_o), 0);
        chk("t3_wv_f1", 32'(w_v_o), 0);
        chk("t3_pending", 32'(pending_o), 0);
        drive(1, 35, 1, 0, 0);
        chk("t3_ready_f2", 32'(upd_ready_o), 0);
        chk("t3_wv_f2", 32'(w_v_o), 0);
        drive(0, 0, 0, 0, 0);
        chk("t3_ready_back", 32'(upd_ready_o), 1);
        chk("t3_wv_after", 32'(w_v_o), 0);
        chk("t3_empty", 32'(empty_o), 1);
        drive(0, 0, 0, 0, 0);
        chk("t3_no_stale", 32'(w_v_o), 0);

        // Full FIFO draining with valid held high; 10 updates wrap the pointers
        for (int i = 0; i < 4; i++) begin
            drive(1, 40 + i, 1'(i), 1, 0);
            q.push_back(40 + i);
        end
        mc = 4; sent = 4; wr = 0;
        for (int cyc = 0; cyc < 40 && wr < 10; cyc++) begin
            drive(sent < 10, 40 + sent, 1'(sent), 0, 0);
            chk("t4_ready", 32'(upd_ready_o), 32'(mc < 4));
            chk("t4_pending", 32'(pending_o), 32'(mc));
            chk("t4_wv", 32'(w_v_o), 32'(mc > 0));
            acc = (sent < 10) && (mc < 4);
            if (mc > 0) begin
                exp_idx = q.pop_front();
                chk("t4_idx", 32'(idx_w_o), 32'(exp_idx));
                chk("t4_c", 32'(correct_o), 32'(exp_idx & 1));
                wr++;
                mc--;
            end
            if (acc) begin
                q.push_back(40 + sent);
                sent++;
                mc++;
            end
        end
        chk("t4_writes", 32'(wr), 10);
        drive(0, 0, 0, 0, 0);
        chk("t4_empty", 32'(empty_o), 1);
        chk("t4_wv_end", 32'(w_v_o), 0);

        // Async reset mid-eFlush
        drive(1, 50, 0, 1, 0);
        drive(1, 51, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        chk("t5_inflush_ready", 32'(upd_ready_o), 0);
        #2 reset_i = 1'b1;
        #1;
        chk("t5_rf_ready", 32'(upd_ready_o), 1);
        chk("t5_rf_wv", 32'(w_v_o), 0);
        chk("t5_rf_empty", 32'(empty_o), 1);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("t5_rf_ready_post", 32'(upd_ready_o), 1);

        // Async reset mid-drain
        drive(1, 60, 0, 0, 0);
        drive(1, 61, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("t5_drain_wv", 32'(w_v_o), 1);
        #2 reset_i = 1'b1;
        #1;
        chk("t5_rd_wv", 32'(w_v_o), 0);
        chk("t5_rd_ready", 32'(upd_ready_o), 1);
        chk("t5_rd_empty", 32'(empty_o), 1);
        chk("t5_rd_pending", 32'(pending_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("t5_rd_no_stale", 32'(w_v_o), 0);

`ifdef BP_FE_BHT_UPD_STATS_EN
        // Stats: 6 writes, then flush with 3 queued
        do_reset();
        chk("st_wr_rst", 32'(stat_wr_o), 0);
        chk("st_drop_rst", 32'(stat_drop_o), 0);
        for (int i = 0; i < 6; i++) drive(1, 70 + i, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 80 + i, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0);
        chk("st_wr", 32'(stat_wr_o), 6);
        chk("st_drop", 32'(stat_drop_o), 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
